// File: rtl/dcache_mem_arbiter.sv
// dcache_mem_arbiter: shares one pipelined Wishbone master between D-cache line refills and write-buffer drains.
// Optional write-starvation guard: define DCACHE_ARB_STARVE_GUARD_EN.
module dcache_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int LINE_W     = 128,
    parameter int STARVE_MAX = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  refill_req_i,
    input  logic [ADDR_W-1:0]                     refill_addr_i,
    output logic                                  refill_valid_o,
    output logic [LINE_W-1:0]                     refill_rdata_o,
    input  logic                                  wb_valid_i,
    input  logic [ADDR_W-1:0]                     wb_addr_i,
    input  logic [31:0]                           wb_data_i,
    input  logic [3:0]                            wb_sel_i,
    output logic                                  wb_pop_o,
    output logic                                  mem_cyc_o,
    output logic                                  mem_stb_o,
    output logic                                  mem_we_o,
    output logic [ADDR_W-$clog2(LINE_W/8)-1:0]    mem_addr_o,
    output logic [LINE_W/8-1:0]                   mem_sel_o,
    output logic [LINE_W-1:0]                     mem_wdata_o,
    input  logic [LINE_W-1:0]                     mem_rdata_i,
    input  logic                                  mem_ack_i,
    input  logic                                  mem_stall_i
);
    localparam int OFF = $clog2(LINE_W / 8);
    localparam int AW  = ADDR_W - OFF;
    localparam int SW  = LINE_W / 8;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [LINE_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              valid_q, valid_d;
    logic [OFF-3:0]    w;
    logic              idle_free, rd_go, wr_go, force_wr;
    logic              unused_bits;

    assign w           = wb_addr_i[OFF-1:2];
    assign unused_bits = ^{wb_addr_i[1:0], refill_addr_i[OFF-1:0]};
    // The refill requester still holds its request in the valid cycle, so no grant is taken then.
    assign idle_free   = (state_q == IDLE) && !valid_q;
    assign rd_go       = idle_free && refill_req_i && !force_wr;
    assign wr_go       = idle_free && wb_valid_i && !rd_go;

`ifdef DCACHE_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] starve_q, starve_d;

    assign force_wr = wb_valid_i && (starve_q == CW'(STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if (rd_go && wb_valid_i && starve_q != CW'(STARVE_MAX)) starve_d = starve_q + 1'b1;
        if (wr_go) starve_d = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) starve_q <= '0;
        else       starve_q <= starve_d;
`else
    logic unused_cfg;
    assign unused_cfg = STARVE_MAX[0];
    assign force_wr   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_go) begin
                    state_d = RD_REQ;
                    addr_d  = refill_addr_i[ADDR_W-1:OFF];
                    sel_d   = '1;
                    wdata_d = '0;
                end else if (wr_go) begin
                    state_d = WR_REQ;
                    addr_d  = wb_addr_i[ADDR_W-1:OFF];
                    sel_d   = SW'(wb_sel_i) << (4 * w);
                    wdata_d = LINE_W'(wb_data_i) << (32 * w);
                end
            end
            RD_REQ:  state_d = mem_stall_i ? RD_REQ : RD_WAIT;
            WR_REQ:  state_d = mem_stall_i ? WR_REQ : WR_WAIT;
            RD_WAIT: begin
                if (mem_ack_i) begin
                    state_d = IDLE;
                    rdata_d = mem_rdata_i;
                    valid_d = 1'b1;
                end
            end
            WR_WAIT: begin
                if (mem_ack_i) begin
                    state_d = IDLE;
                    wdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
        end

    assign mem_cyc_o      = state_q != IDLE;
    assign mem_stb_o      = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign mem_we_o       = (state_q == WR_REQ) || (state_q == WR_WAIT);
    assign mem_addr_o     = addr_q;
    assign mem_sel_o      = sel_q;
    assign mem_wdata_o    = wdata_q;
    assign wb_pop_o       = (state_q == WR_WAIT) && mem_ack_i;
    assign refill_valid_o = valid_q;
    assign refill_rdata_o = rdata_q;
endmodule

// File: tb/tb_dcache_mem_arbiter.sv
// tb_dcache_mem_arbiter: scoreboard bench; a bus slave model acks accepted strobes and queues expected refill data.
module tb_dcache_mem_arbiter;
    logic         clk_i = 1'b0, rst_i = 1'b1;
    logic         refill_req_i = 1'b0;
    logic [31:0]  refill_addr_i = '0;
    logic         refill_valid_o;
    logic [127:0] refill_rdata_o;
    logic         wb_valid_i = 1'b0;
    logic [31:0]  wb_addr_i = '0, wb_data_i = '0;
    logic [3:0]   wb_sel_i = '0;
    logic         wb_pop_o, mem_cyc_o, mem_stb_o, mem_we_o;
    logic [27:0]  mem_addr_o;
    logic [15:0]  mem_sel_o;
    logic [127:0] mem_wdata_o;
    logic [127:0] mem_rdata_i = '0;
    logic         mem_ack_i = 1'b0, mem_stall_i = 1'b0;

    typedef struct packed {
        logic         we;
        logic [27:0]  addr;
        logic [15:0]  sel;
        logic [127:0] wdata;
    } req_t;

    req_t         exp_req[$];
    logic [127:0] exp_rd[$];
    logic [127:0] last_rd = '0;
    int           total = 0, bad = 0, grants = 0, pops = 0, cnt = 0, ack_dly = 1;
    logic         pend_rd = 1'b0, early_ack = 1'b0, man_ack = 1'b0;

    dcache_mem_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .refill_req_i(refill_req_i), .refill_addr_i(refill_addr_i),
        .refill_valid_o(refill_valid_o), .refill_rdata_o(refill_rdata_o),
        .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_sel_i(wb_sel_i),
        .wb_pop_o(wb_pop_o),
        .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .mem_stall_i(mem_stall_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic req_t mk(input logic we, input logic [27:0] a, input logic [15:0] s, input logic [127:0] d);
        mk = {we, a, s, d};
    endfunction

    // Monitor: compares each accepted strobe and each refill pulse against the scoreboard.
    initial begin : monitor
        req_t got, want;
        logic [127:0] rd;
        logic do_early;
        forever begin
            @(negedge clk_i);
            do_early = 1'b0;
            if (rst_i) cnt = 0;
            else begin
                if (mem_stb_o && !mem_stall_i) begin
                    got = {mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o};
                    grants++;
                    total++;
                    if (exp_req.size() == 0) begin
                        bad++;
                        $display("FAIL grant: unexpected grant we=%b addr=%h", mem_we_o, mem_addr_o);
                    end else begin
                        want = exp_req.pop_front();
                        if (got !== want) begin
                            bad++;
                            $display("FAIL grant: got we=%b addr=%h sel=%h wdata=%h, want we=%b addr=%h sel=%h wdata=%h",
                                     got.we, got.addr, got.sel, got.wdata, want.we, want.addr, want.sel, want.wdata);
                        end
                    end
                    cnt = ack_dly;
                    pend_rd = !mem_we_o;
                    do_early = early_ack;
                end
                if (refill_valid_o) begin
                    total++;
                    if (exp_rd.size() == 0) begin
                        bad++;
                        $display("FAIL refill: unexpected refill_valid_o, rdata=%h", refill_rdata_o);
                    end else begin
                        rd = exp_rd.pop_front();
                        last_rd = rd;
                        if (refill_rdata_o !== rd) begin
                            bad++;
                            $display("FAIL refill: rdata got %h want %h", refill_rdata_o, rd);
                        end
                    end
                end
                if (wb_pop_o) pops++;
            end
            if (do_early) begin
                #1;
                mem_ack_i = 1'b1;
            end
        end
    end

    initial begin : slave
        forever begin
            @(posedge clk_i);
            #1;
            if (cnt > 0) begin
                cnt--;
                mem_ack_i = (cnt == 0) || man_ack;
                if (cnt == 0) begin
                    mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
                    if (pend_rd) exp_rd.push_back(mem_rdata_i);
                end
            end else mem_ack_i = man_ack;
        end
    end

    task automatic do_read(input logic [31:0] a, output int stb_c, output int ack_c, output int val_c);
        stb_c = -1; ack_c = -1; val_c = -1;
        @(posedge clk_i); #1;
        refill_req_i = 1'b1;
        refill_addr_i = a;
        for (int n = 0; n < 100 && val_c < 0; n++) begin
            @(negedge clk_i);
            if (mem_stb_o && stb_c < 0) stb_c = n;
            if (mem_ack_i && mem_cyc_o && !mem_stb_o) ack_c = n;
            if (refill_valid_o) val_c = n;
        end
        total++;
        if (val_c < 0) begin
            bad++;
            $display("FAIL read_timeout: no refill_valid_o for addr %h", a);
        end
        @(posedge clk_i); #1;
        refill_req_i = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int pop_c;
        pop_c = -1;
        @(posedge clk_i); #1;
        wb_valid_i = 1'b1; wb_addr_i = a; wb_data_i = d; wb_sel_i = s;
        for (int n = 0; n < 100 && pop_c < 0; n++) begin
            @(negedge clk_i);
            if (wb_pop_o) pop_c = n;
        end
        total++;
        if (pop_c < 0) begin
            bad++;
            $display("FAIL write_timeout: no wb_pop_o for addr %h", a);
        end
        @(posedge clk_i); #1;
        wb_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        total += 5;
        if ({mem_cyc_o, mem_stb_o, mem_we_o, wb_pop_o, refill_valid_o} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl: cyc/stb/we/pop/valid got %b want 00000",
                            {mem_cyc_o, mem_stb_o, mem_we_o, wb_pop_o, refill_valid_o});
        end
        if (mem_sel_o !== 16'h0) begin bad++; $display("FAIL reset_sel: got %h want 0", mem_sel_o); end
        if (mem_addr_o !== 28'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", mem_addr_o); end
        if (mem_wdata_o !== 128'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", mem_wdata_o); end
        if (refill_rdata_o !== 128'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", refill_rdata_o); end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_read();
        int s, a, v;
        ack_dly = 3;
        exp_req.push_back(mk(1'b0, 28'h123, 16'hFFFF, 128'h0));
        do_read(32'h0000_1234, s, a, v);
        total += 3;
        if (s !== 1) begin bad++; $display("FAIL read_grant: stb at cycle %0d want 1", s); end
        if (a !== 4) begin bad++; $display("FAIL read_ack: ack at cycle %0d want 4", a); end
        if (v !== 5) begin bad++; $display("FAIL read_valid: valid at cycle %0d want 5", v); end
    endtask

    task automatic test_write();
        int p0;
        ack_dly = 2;
        p0 = pops;
        exp_req.push_back(mk(1'b1, 28'h8, 16'h0C00, 128'h0000_0000_DEADBEEF_0000_0000_0000_0000));
        do_write(32'h88, 32'hDEADBEEF, 4'hC);
        repeat (3) @(negedge clk_i);
        total += 3;
        if (pops - p0 !== 1) begin bad++; $display("FAIL write_pop: pops %0d want 1", pops - p0); end
        if (mem_wdata_o !== 128'h0) begin bad++; $display("FAIL write_idle_wdata: got %h want 0", mem_wdata_o); end
        if (refill_rdata_o !== last_rd) begin bad++; $display("FAIL rdata_hold: got %h want %h", refill_rdata_o, last_rd); end
        exp_req.push_back(mk(1'b1, 28'h1, 16'h3000, 128'h12345678_0000_0000_0000_0000_0000_0000));
        do_write(32'h1C, 32'h12345678, 4'h3);
        exp_req.push_back(mk(1'b1, 28'h2, 16'h000F, 128'h0000_0000_0000_0000_0000_0000_CAFEF00D));
        do_write(32'h20, 32'hCAFEF00D, 4'hF);
        repeat (3) @(negedge clk_i);
        total++;
        if (pops - p0 !== 3) begin bad++; $display("FAIL write_pop3: pops %0d want 3", pops - p0); end
    endtask

    task automatic test_stall();
        int seen, v;
        ack_dly = 1;
        seen = 0; v = -1;
        mem_stall_i = 1'b1;
        exp_req.push_back(mk(1'b0, 28'h567, 16'hFFFF, 128'h0));
        @(posedge clk_i); #1;
        refill_req_i = 1'b1; refill_addr_i = 32'h5670;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk_i);
            seen = mem_stb_o;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk_i);
            total++;
            if ({mem_cyc_o, mem_stb_o, mem_addr_o, mem_sel_o} !== {1'b1, 1'b1, 28'h567, 16'hFFFF}) begin
                bad++; $display("FAIL stall_hold[%0d]: cyc=%b stb=%b addr=%h sel=%h want 1 1 567 ffff",
                                i, mem_cyc_o, mem_stb_o, mem_addr_o, mem_sel_o);
            end
        end
        @(posedge clk_i); #1;
        mem_stall_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        total++;
        if ({mem_cyc_o, mem_stb_o} !== 2'b10) begin
            bad++; $display("FAIL stall_release: cyc/stb got %b want 10", {mem_cyc_o, mem_stb_o});
        end
        for (int n = 0; n < 20 && v < 0; n++) begin
            if (refill_valid_o) v = n;
            else @(negedge clk_i);
        end
        total++;
        if (v < 0) begin bad++; $display("FAIL stall_timeout: no refill_valid_o"); end
        @(posedge clk_i); #1;
        refill_req_i = 1'b0;
    endtask

    task automatic test_stray_ack();
        int s, a, v, p0;
        ack_dly = 2;
        early_ack = 1'b1;
        exp_req.push_back(mk(1'b0, 28'hABC, 16'hFFFF, 128'h0));
        do_read(32'h0000_ABC0, s, a, v);
        total++;
        if (v !== 4) begin bad++; $display("FAIL stray_ack_read: valid at cycle %0d want 4", v); end
        p0 = pops;
        exp_req.push_back(mk(1'b1, 28'h3, 16'h00F0, 128'h0000_0000_0000_0000_0BADCAFE_0000_0000));
        do_write(32'h34, 32'h0BADCAFE, 4'hF);
        early_ack = 1'b0;
        repeat (3) @(negedge clk_i);
        total++;
        if (pops - p0 !== 1) begin bad++; $display("FAIL stray_ack_pop: pops %0d want 1", pops - p0); end
    endtask

    task automatic test_back_to_back();
        int s, a, v;
        ack_dly = 1;
        exp_req.push_back(mk(1'b0, 28'h1000, 16'hFFFF, 128'h0));
        do_read(32'h0001_0008, s, a, v);
        total++;
        if (v !== 3) begin bad++; $display("FAIL b2b_read1: valid at cycle %0d want 3", v); end
        exp_req.push_back(mk(1'b1, 28'hFFFFFFF, 16'hF000, 128'h80000001_0000_0000_0000_0000_0000_0000));
        do_write(32'hFFFF_FFFC, 32'h80000001, 4'hF);
        exp_req.push_back(mk(1'b0, 28'hFFFFFFF, 16'hFFFF, 128'h0));
        do_read(32'hFFFF_FFF0, s, a, v);
        total++;
        if (v !== 3) begin bad++; $display("FAIL b2b_read2: valid at cycle %0d want 3", v); end
    endtask

    task automatic test_starve();
        int g0, p0, done, want_pops;
        ack_dly = 1;
        g0 = grants; p0 = pops; done = 0;
        for (int i = 0; i < 10; i++) begin
`ifdef DCACHE_ARB_STARVE_GUARD_EN
            if (i % 5 == 4) exp_req.push_back(mk(1'b1, 28'h0, 16'h00F0, 128'h0000_0000_0000_0000_11111111_0000_0000));
            else exp_req.push_back(mk(1'b0, 28'h400, 16'hFFFF, 128'h0));
`else
            exp_req.push_back(mk(1'b0, 28'h400, 16'hFFFF, 128'h0));
`endif
        end
`ifdef DCACHE_ARB_STARVE_GUARD_EN
        want_pops = 2;
`else
        want_pops = 0;
`endif
        @(posedge clk_i); #1;
        refill_req_i = 1'b1; refill_addr_i = 32'h4000;
        wb_valid_i = 1'b1; wb_addr_i = 32'h4; wb_data_i = 32'h11111111; wb_sel_i = 4'hF;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk_i);
            done = (grants - g0 >= 10);
        end
        @(posedge clk_i); #1;
        refill_req_i = 1'b0; wb_valid_i = 1'b0;
        repeat (10) @(negedge clk_i);
        total += 2;
        if (grants - g0 !== 10) begin bad++; $display("FAIL starve_grants: got %0d want 10", grants - g0); end
        if (pops - p0 !== want_pops) begin bad++; $display("FAIL starve_pops: got %0d want %0d", pops - p0, want_pops); end
    endtask

    task automatic test_reset_abort();
        int p0, inwait, s, a, v;
        ack_dly = 20;
        inwait = 0;
        exp_req.push_back(mk(1'b1, 28'h9, 16'h000F, 128'h0000_0000_0000_0000_0000_0000_A5A5A5A5));
        @(posedge clk_i); #1;
        wb_valid_i = 1'b1; wb_addr_i = 32'h90; wb_data_i = 32'hA5A5A5A5; wb_sel_i = 4'hF;
        for (int n = 0; n < 20 && !inwait; n++) begin
            @(negedge clk_i);
            inwait = mem_cyc_o && !mem_stb_o;
        end
        total++;
        if (!inwait) begin bad++; $display("FAIL abort_wait: WR_WAIT never reached"); end
        p0 = pops;
        @(posedge clk_i); #1;
        rst_i = 1'b1; wb_valid_i = 1'b0;
        @(negedge clk_i);
        total++;
        if ({mem_cyc_o, mem_stb_o, mem_we_o, wb_pop_o, refill_valid_o, mem_wdata_o, refill_rdata_o} !== '0) begin
            bad++; $display("FAIL abort_in_reset: cyc=%b stb=%b we=%b pop=%b valid=%b want all 0",
                            mem_cyc_o, mem_stb_o, mem_we_o, wb_pop_o, refill_valid_o);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0; man_ack = 1'b1; last_rd = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            total++;
            if ({mem_cyc_o, mem_stb_o, mem_we_o, wb_pop_o, refill_valid_o} !== 5'b0) begin
                bad++; $display("FAIL abort_after[%0d]: cyc/stb/we/pop/valid got %b want 00000",
                                i, {mem_cyc_o, mem_stb_o, mem_we_o, wb_pop_o, refill_valid_o});
            end
        end
        @(posedge clk_i); #1;
        man_ack = 1'b0;
        total++;
        if (pops !== p0) begin bad++; $display("FAIL abort_pop: pops %0d want %0d", pops, p0); end
        ack_dly = 1;
        exp_req.push_back(mk(1'b0, 28'h77, 16'hFFFF, 128'h0));
        do_read(32'h0000_0770, s, a, v);
        total++;
        if (v !== 3) begin bad++; $display("FAIL abort_recover: valid at cycle %0d want 3", v); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_stall();
        test_stray_ack();
        test_back_to_back();
        test_starve();
        test_reset_abort();
        repeat (5) @(negedge clk_i);
        total += 2;
        if (exp_req.size() != 0) begin bad++; $display("FAIL leftover_req: %0d grants never seen", exp_req.size()); end
        if (exp_rd.size() != 0) begin bad++; $display("FAIL leftover_rd: %0d refills never seen", exp_rd.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
